player1_recorder: RTL
=====================

PLAYER1_RECORDER -- requirements
Module: player1_recorder

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set the number of pattern slots.
REQ-002 Parameter AW, default 5, SHALL set the address width and satisfy 2^AW = DEPTH.
REQ-003 clock  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-004 resetn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 tick  input  1  SHALL be a one-cycle sample strobe; sampling occurs only in cycles where tick=1.
REQ-006 enable  input  1  SHALL indicate that it is player 1's turn (high = recording permitted).
REQ-007 key_n  input  1  SHALL be the raw active-low pattern button (0 = pressed = symbol 1).
REQ-008 done_n  input  1  SHALL be the raw active-low finish button.
REQ-009 rd_addr  input  AW  SHALL be the playback read address.
REQ-010 rd_data  output  1  SHALL be the stored symbol at rd_addr.
REQ-011 length  output  AW+1  SHALL be the number of symbols recorded, 0..DEPTH.
REQ-012 ready  output  1  SHALL be high when the pattern is complete (state DONE).
REQ-013 recording  output  1  SHALL be high in state RECORD.
REQ-014 full  output  1  SHALL be high when length = DEPTH.
REQ-015 state  output  2  SHALL show the FSM encoding for the HEX debug display.

Function
REQ-016 key_n and done_n SHALL each pass through a 2-flop synchronizer before use; key = ~key_n_sync2.
REQ-017 done_evt SHALL be high for exactly one cycle when synchronized done_n goes 1->0; a held button SHALL produce only one event.
REQ-018 The FSM SHALL have the states IDLE=0, ARMED=1, RECORD=2 and DONE=3.
REQ-019 IDLE: when enable=1 the FSM SHALL go to ARMED next cycle; length and write pointer SHALL clear to 0.
REQ-020 ARMED: on tick with key=1, the FSM SHALL write 1 to slot 0, set length=1 and go to RECORD; a tick with key=0 SHALL record nothing, so leading blanks are discarded.
REQ-021 ARMED: done_evt SHALL go to DONE with length=0.
REQ-022 RECORD: each tick SHALL write key to mem[length] and increment length by 1.
REQ-023 RECORD: done_evt SHALL go to DONE; if tick coincides with done_evt, the sample SHALL be written first and counted in length.
REQ-024 RECORD: the write that makes length=DEPTH SHALL also transition to DONE; no further writes SHALL occur (no wrap-around).
REQ-025 DONE: memory and length SHALL hold; tick and key SHALL be ignored.
REQ-026 In any state, enable=0 SHALL return the FSM to IDLE next cycle; memory contents need not be cleared.
REQ-027 rd_data SHALL be registered with 1-cycle latency: rd_data(t+1) = mem[rd_addr(t)] if rd_addr(t) < length, else 0.
REQ-028 A read to the address being written in the same cycle SHALL return the old contents.
REQ-029 length arithmetic SHALL be AW+1 bits wide and saturate at DEPTH.

Reset
REQ-030 With resetn=0 at a rising edge, the block SHALL enter IDLE with length=0, ready=0, recording=0, full=0, state=0, rd_data=0, and synchronizers and edge detector preset to 1 (released).
REQ-031 Reset SHALL take priority over all other inputs, including mid-RECORD; memory contents are don't-care after reset.

Verification
REQ-032 Reset mid-RECORD after 5 samples -> next cycle state=0, length=0, ready=0.
REQ-033 enable=1; key pattern per tick 0,0,1,0,1,1 then done press -> length=4, memory 1,0,1,1, ready=1, state=3.
REQ-034 Continuous ticks with key alternating from first press and no done -> exactly 32 writes, full=1, ready=1; 33rd tick leaves length=32.
REQ-035 tick and done_evt in the same cycle during RECORD with length=7, key=1 -> length=8, mem[7]=1, DONE.
REQ-036 In DONE with length=4: rd_addr=2 -> rd_data=1 one cycle later; rd_addr=9 -> rd_data=0; done_n held low for 100 cycles -> single event.
REQ-037 enable dropped in DONE, then raised -> IDLE, then ARMED with length=0; a new pattern records from slot 0.

Source files
------------

// File: rtl/player1_recorder.sv
// rtl/player1_recorder.sv - player 1 pattern recorder: synchronized buttons, record FSM, pattern memory
module player1_recorder #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          tick,
   input  logic          enable,
   input  logic          key_n,
   input  logic          done_n,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_data,
   output logic [AW:0]   length,
   output logic          ready,
   output logic          recording,
   output logic          full,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RECORD = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   state_t state_q;
   logic   key_s1, key_s2, done_s1, done_s2, done_prev;
   logic   key, done_evt, wr_en;
   logic   mem [DEPTH];

   // Buttons idle high, so the synchronizers and edge detector reset to "released".
   always_ff @(posedge clock) begin
      if (!resetn) begin
         key_s1    <= 1'b1;
         key_s2    <= 1'b1;
         done_s1   <= 1'b1;
         done_s2   <= 1'b1;
         done_prev <= 1'b1;
      end else begin
         key_s1    <= key_n;
         key_s2    <= key_s1;
         done_s1   <= done_n;
         done_s2   <= done_s1;
         done_prev <= done_s2;
      end
   end

   assign key      = ~key_s2;
   assign done_evt = done_prev & ~done_s2;

   // ARMED only accepts a pressed key, so leading blanks never reach memory.
   assign wr_en = resetn & enable & tick &
                  (((state_q == ARMED) & key) | ((state_q == RECORD) & (length != FULL_LEN)));

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         length  <= '0;
      end else if (state_q == IDLE) begin
         length <= '0;
         if (enable)
            state_q <= ARMED;
      end else if (!enable) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            ARMED: begin
               if (wr_en) begin
                  length  <= ONE;
                  state_q <= (done_evt || (FULL_LEN == ONE)) ? DONE : RECORD;
               end else if (done_evt) begin
                  state_q <= DONE;
               end
            end
            RECORD: begin
               // A tick coinciding with the finish press is still recorded.
               if (wr_en) begin
                  length <= length + ONE;
                  if (done_evt || (length + ONE == FULL_LEN))
                     state_q <= DONE;
               end else if (done_evt) begin
                  state_q <= DONE;
               end
            end
            default: state_q <= state_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[length[AW-1:0]] <= key;
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         rd_data <= 1'b0;
      else
         rd_data <= ({1'b0, rd_addr} < length) ? mem[rd_addr] : 1'b0;
   end

   assign state     = state_q;
   assign ready     = (state_q == DONE);
   assign recording = (state_q == RECORD);
   assign full      = (length == FULL_LEN);

endmodule
